// File: rtl/thirty_two_bit_alu.sv
// thirty_two_bit_alu: registered ALU with set/zero/overflow flags, one-cycle latency.
// Optional macro ALU_SLTU_EN enables unsigned set-less-than on op 101.
module thirty_two_bit_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             set,
    output logic             zero,
    output logic             overflow
);
    logic [WIDTH-1:0] sum, diff, result_d, result_q;
    logic             add_ovf, sub_ovf, slt, sltu, ovf_d;
    logic             set_q, zero_q, ovf_q;
    always_comb begin
        sum     = a + b;
        diff    = a + ~b + 1'b1;
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        slt     = diff[WIDTH-1] ^ sub_ovf;
`ifdef ALU_SLTU_EN
        sltu    = a < b;
`else
        sltu    = 1'b0;
`endif
        result_d = op == 3'b000 ? a & b :
                   op == 3'b001 ? a | b :
                   op == 3'b010 ? sum :
                   op == 3'b011 ? a ^ b :
                   op == 3'b100 ? ~(a | b) :
                   op == 3'b101 ? {{(WIDTH-1){1'b0}}, sltu} :
                   op == 3'b110 ? diff :
                                  {{(WIDTH-1){1'b0}}, slt};
        ovf_d = op == 3'b010 ? add_ovf : op == 3'b110 ? sub_ovf : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            set_q    <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            set_q    <= slt;
            zero_q   <= result_d == '0;
            ovf_q    <= ovf_d;
        end
    end
    assign result   = result_q;
    assign set      = set_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_thirty_two_bit_alu.sv
// tb_thirty_two_bit_alu: directed vector table, reset/hold sequences and randomized model check.
module tb_thirty_two_bit_alu;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        rst;
        logic [31:0] r;
        logic        s;
        logic        z;
        logic        o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic [31:0] result;
    logic        set, zero, overflow;
    int          n_vec = 0, n_bad = 0;
    vec_t        tbl[$];

    thirty_two_bit_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op),
        .result(result), .set(set), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] a_v, input logic [31:0] b_v, input logic [2:0] op_v,
                                input logic [31:0] r_v, input logic s_v, input logic z_v, input logic o_v);
        vec_t v;
        v.a = a_v; v.b = b_v; v.op = op_v; v.rst = 1'b0;
        v.r = r_v; v.s = s_v; v.z = z_v; v.o = o_v;
        return v;
    endfunction

    // Reference: signed/unsigned values as wide integers, overflow = result out of 32-bit signed range.
    function automatic vec_t model(input logic [31:0] a_v, input logic [31:0] b_v, input logic [2:0] op_v, input logic rst_v);
        vec_t   v;
        longint sa = longint'($signed(a_v));
        longint sb = longint'($signed(b_v));
        longint ua = longint'({32'b0, a_v});
        longint ub = longint'({32'b0, b_v});
        longint wide;
        longint lim_hi = 64'sd2147483647;
        longint lim_lo = -64'sd2147483648;
        v.a = a_v; v.b = b_v; v.op = op_v; v.rst = rst_v; v.o = 1'b0;
        case (op_v)
            3'd0: v.r = a_v & b_v;
            3'd1: v.r = a_v | b_v;
            3'd2: begin wide = ua + ub; v.r = wide[31:0]; v.o = (sa + sb > lim_hi) || (sa + sb < lim_lo); end
            3'd3: v.r = a_v ^ b_v;
            3'd4: v.r = ~(a_v | b_v);
`ifdef ALU_SLTU_EN
            3'd5: v.r = (ua < ub) ? 32'd1 : 32'd0;
`else
            3'd5: v.r = 32'd0;
`endif
            3'd6: begin wide = ua - ub; v.r = wide[31:0]; v.o = (sa - sb > lim_hi) || (sa - sb < lim_lo); end
            default: v.r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        v.s = sa < sb;
        v.z = v.r == 32'd0;
        if (rst_v) begin v.r = '0; v.s = 1'b0; v.z = 1'b1; v.o = 1'b0; end
        return v;
    endfunction

    task automatic check(input string name, input vec_t v);
        n_vec++;
        if (result !== v.r || set !== v.s || zero !== v.z || overflow !== v.o) begin
            n_bad++;
            $display("FAIL %s a=%h b=%h op=%0d rst=%0b: got r=%h s=%0b z=%0b o=%0b, want r=%h s=%0b z=%0b o=%0b",
                     name, v.a, v.b, v.op, v.rst, result, set, zero, overflow, v.r, v.s, v.z, v.o);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        a = v.a; b = v.b; op = v.op; reset = v.rst;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    initial begin
        vec_t v;
        tbl.push_back(mk(32'h00000043, 32'h8000007F, 3'b001, 32'h8000007F, 0, 0, 0));
        tbl.push_back(mk(32'h00000043, 32'h8000007F, 3'b000, 32'h00000043, 0, 0, 0));
        tbl.push_back(mk(32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 0, 0, 1));
        tbl.push_back(mk(32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1, 0, 1));
        tbl.push_back(mk(32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 0, 1, 0));
        tbl.push_back(mk(32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1, 0, 0));
        tbl.push_back(mk(32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000000, 1, 1, 0));
`ifdef ALU_SLTU_EN
        tbl.push_back(mk(32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000001, 0, 0, 0));
`else
        tbl.push_back(mk(32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000000, 0, 1, 0));
`endif
        tbl.push_back(mk(32'hF0F0F0F0, 32'h0F0F0F0F, 3'b100, 32'h00000000, 1, 1, 0));
        tbl.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'h00000000, 0, 1, 0));
        tbl.push_back(mk(32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 0, 1, 1));
        tbl.push_back(mk(32'h00000000, 32'h80000000, 3'b110, 32'h80000000, 0, 0, 1));

        // Reset wins over an overflowing ADD, then the same inputs land one edge later.
        v = mk(32'h40000000, 32'h40000000, 3'b010, 32'h0, 0, 1, 0);
        v.rst = 1'b1;
        apply("reset_prio", v);
        apply("first_after_reset", mk(32'h40000000, 32'h40000000, 3'b010, 32'h80000000, 0, 0, 1));

        foreach (tbl[i]) apply($sformatf("table%0d", i), tbl[i]);

        // Outputs must hold while inputs change between edges.
        v = tbl[2];
        a = 32'h0; b = 32'h0; op = 3'b110;
        #3;
        check("hold", model(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b0));
        @(posedge clk);
        #1;
        check("after_hold", model(32'h0, 32'h0, 3'b110, 1'b0));

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra = $urandom, rb = $urandom;
            logic [2:0]  rop = 3'($urandom_range(0, 7));
            logic        rrst = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = {~rb[31], rb[30:0]};
            apply("random", model(ra, rb, rop, rrst));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
